// File: rtl/csr_trap_seq.sv
// csr_trap_seq
// Sequences the CSR side effects of trap entry and MRET onto the csrfile's
// single sequencer write channel. Ordinary commit-stage CSR writes share the
// channel and win while the sequencer is idle. The block finishes each
// sequence with a one-cycle done pulse that carries the fetch redirect PC.
//
// Ports
//   clk, rst                        clock, asynchronous active-low reset
//   commit_req/addr/data            commit-stage CSR write request
//   commit_grant                    commit write forwarded this cycle
//   trap_valid/pc/cause/tval        trap entry request and its CSR values
//   mret_valid                      MRET request
//   req_ready                       trap/mret accepted when valid && ready
//   csrf_all_mstatus/mtvec/mepc_data  current CSR values from csrfile
//   seq_csrf_write_addr/data, seq_csrf_we  write channel to csrfile
//   seq_done, seq_redirect_pc       completion pulse and redirect target
//   seq_busy                        sequencer not idle
//
// Configuration
//   CSR_TRAP_MTVAL_EN  when defined, trap entry also writes mtval (done at
//                      T+5); otherwise mtval is skipped (done at T+4).
module csr_trap_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_req,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  input  logic [DATA_WIDTH-1:0] commit_data,
  output logic                  commit_grant,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_tval,
  input  logic                  mret_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] csrf_all_mstatus_data,
  input  logic [DATA_WIDTH-1:0] csrf_all_mtvec_data,
  input  logic [DATA_WIDTH-1:0] csrf_all_mepc_data,
  output logic [ADDR_WIDTH-1:0] seq_csrf_write_addr,
  output logic [DATA_WIDTH-1:0] seq_csrf_write_data,
  output logic                  seq_csrf_we,
  output logic                  seq_done,
  output logic [DATA_WIDTH-1:0] seq_redirect_pc,
  output logic                  seq_busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MSTATUS = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC    = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE  = ADDR_WIDTH'(12'h342);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTVAL   = ADDR_WIDTH'(12'h343);
  // Clears the two low bits: PCs and the mtvec base are word aligned.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK   = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    R_MSTATUS = 3'd5,
    DONE      = 3'd6
  } state_e;

  state_e                  state_r;
  logic [DATA_WIDTH-1:0]   pc_r;
  logic [DATA_WIDTH-1:0]   cause_r;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   redirect_r;
  logic                    grant_s;
  logic                    ready_s;
  logic                    we_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]   data_s;

`ifdef CSR_TRAP_MTVAL_EN
  logic [DATA_WIDTH-1:0]   tval_r;
`else
  logic                    unused_tval_s;
  assign unused_tval_s = ^trap_tval;
`endif

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP <= M-mode.
  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Sequencer FSM: request capture, state advance, done pulse and redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      pc_r       <= '0;
      cause_r    <= '0;
`ifdef CSR_TRAP_MTVAL_EN
      tval_r     <= '0;
`endif
      done_r     <= 1'b0;
      redirect_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Commit is older in program order, so it blocks acceptance.
          if (!commit_req && trap_valid) begin
            pc_r    <= trap_pc;
            cause_r <= trap_cause;
`ifdef CSR_TRAP_MTVAL_EN
            tval_r  <= trap_tval;
`endif
            state_r <= W_MEPC;
          end else if (!commit_req && mret_valid) begin
            state_r <= R_MSTATUS;
          end else begin
            state_r <= IDLE;
          end
        end
        W_MEPC:   state_r <= W_MCAUSE;
`ifdef CSR_TRAP_MTVAL_EN
        W_MCAUSE: state_r <= W_MTVAL;
`else
        W_MCAUSE: state_r <= W_MSTATUS;
`endif
        W_MTVAL:  state_r <= W_MSTATUS;
        W_MSTATUS: begin
          state_r    <= DONE;
          done_r     <= 1'b1;
          redirect_r <= csrf_all_mtvec_data & ALIGN_MASK;
        end
        R_MSTATUS: begin
          state_r    <= DONE;
          done_r     <= 1'b1;
          redirect_r <= csrf_all_mepc_data & ALIGN_MASK;
        end
        DONE:     state_r <= IDLE;
        default:  state_r <= IDLE;
      endcase
    end
  end

  // Write channel mux: commit pass-through in IDLE, sequencer writes otherwise.
  always_comb begin
    grant_s = 1'b0;
    ready_s = 1'b0;
    we_s    = 1'b0;
    addr_s  = '0;
    data_s  = '0;
    case (state_r)
      IDLE: begin
        if (rst && commit_req) begin
          grant_s = 1'b1;
          we_s    = 1'b1;
          addr_s  = commit_addr;
          data_s  = commit_data;
        end else begin
          ready_s = rst;
        end
      end
      W_MEPC: begin
        we_s   = 1'b1;
        addr_s = ADDR_MEPC;
        data_s = pc_r & ALIGN_MASK;
      end
      W_MCAUSE: begin
        we_s   = 1'b1;
        addr_s = ADDR_MCAUSE;
        data_s = cause_r;
      end
      W_MTVAL: begin
`ifdef CSR_TRAP_MTVAL_EN
        we_s   = 1'b1;
        addr_s = ADDR_MTVAL;
        data_s = tval_r;
`else
        we_s   = 1'b0;
`endif
      end
      // mstatus is taken live: only the sequencer writes it while busy.
      W_MSTATUS: begin
        we_s   = 1'b1;
        addr_s = ADDR_MSTATUS;
        data_s = trap_mstatus(csrf_all_mstatus_data);
      end
      R_MSTATUS: begin
        we_s   = 1'b1;
        addr_s = ADDR_MSTATUS;
        data_s = mret_mstatus(csrf_all_mstatus_data);
      end
      DONE:    we_s = 1'b0;
      default: we_s = 1'b0;
    endcase
  end

  assign commit_grant        = grant_s;
  assign req_ready           = ready_s;
  assign seq_csrf_we         = we_s;
  assign seq_csrf_write_addr = addr_s;
  assign seq_csrf_write_data = data_s;
  assign seq_done            = done_r;
  assign seq_redirect_pc     = redirect_r;
  assign seq_busy            = (state_r != IDLE);

endmodule

// File: tb/tb_csr_trap_seq.sv
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_req = 1'b0;
  logic [11:0] commit_addr = 12'h000;
  logic [31:0] commit_data = 32'h0;
  logic        commit_grant;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        mret_valid = 1'b0;
  logic        req_ready;
  logic [31:0] mstatus_in = 32'h0;
  logic [31:0] mtvec_in = 32'h0;
  logic [31:0] mepc_in = 32'h0;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_we;
  logic        seq_done;
  logic [31:0] seq_redirect_pc;
  logic        seq_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
    logic        grant;
  } wr_t;
  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  csr_trap_seq #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .commit_req(commit_req), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_grant(commit_grant),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .req_ready(req_ready),
    .csrf_all_mstatus_data(mstatus_in), .csrf_all_mtvec_data(mtvec_in),
    .csrf_all_mepc_data(mepc_in),
    .seq_csrf_write_addr(wr_addr), .seq_csrf_write_data(wr_data), .seq_csrf_we(wr_we),
    .seq_done(seq_done), .seq_redirect_pc(seq_redirect_pc), .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write and every done pulse must match the next expectation.
  initial begin
    wr_t e;
    dn_t d;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (wr_we) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, wr_addr, wr_data);
          end else begin
            e = wq.pop_front();
            if (e.cyc != cyc || e.addr != wr_addr || e.data != wr_data || e.grant != commit_grant) begin
              errors++;
              $display("FAIL write got cyc=%0d addr=%h data=%h grant=%b expected cyc=%0d addr=%h data=%h grant=%b",
                       cyc, wr_addr, wr_data, commit_grant, e.cyc, e.addr, e.data, e.grant);
            end
          end
        end
        if (seq_done) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d redirect=%h", cyc, seq_redirect_pc);
          end else begin
            d = dq.pop_front();
            if (d.cyc != cyc || d.pc != seq_redirect_pc) begin
              errors++;
              $display("FAIL done got cyc=%0d redirect=%h expected cyc=%0d redirect=%h",
                       cyc, seq_redirect_pc, d.cyc, d.pc);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue a trap in the current cycle and queue its expected write sequence.
  task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                          input logic [31:0] ms, input logic [31:0] mtvec,
                          input logic [31:0] exp_mepc, input logic [31:0] exp_ms,
                          input logic [31:0] exp_redir);
    int k;
    int n;
    trap_pc = pc; trap_cause = cause; trap_tval = tval;
    mstatus_in = ms; mtvec_in = mtvec;
    trap_valid = 1'b1;
    k = cyc;
    wq.push_back('{k + 1, 12'h341, exp_mepc, 1'b0});
    wq.push_back('{k + 2, 12'h342, cause, 1'b0});
`ifdef CSR_TRAP_MTVAL_EN
    wq.push_back('{k + 3, 12'h343, tval, 1'b0});
    n = k + 4;
`else
    n = k + 3;
`endif
    wq.push_back('{n, 12'h300, exp_ms, 1'b0});
    dq.push_back('{n + 1, exp_redir});
    tick();
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    chk("busy_in_trap", {31'b0, seq_busy}, 32'h1);
    chk("ready_in_trap", {31'b0, req_ready}, 32'h0);
    repeat (6) tick();
  endtask

  task automatic run_mret(input logic [31:0] ms, input logic [31:0] mepc,
                          input logic [31:0] exp_ms, input logic [31:0] exp_redir);
    int k;
    mstatus_in = ms; mepc_in = mepc;
    mret_valid = 1'b1;
    k = cyc;
    wq.push_back('{k + 1, 12'h300, exp_ms, 1'b0});
    dq.push_back('{k + 2, exp_redir});
    tick();
    mret_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("rst_we", {31'b0, wr_we}, 32'h0);
    chk("rst_grant", {31'b0, commit_grant}, 32'h0);
    chk("rst_done", {31'b0, seq_done}, 32'h0);
    chk("rst_busy", {31'b0, seq_busy}, 32'h0);
    chk("rst_addr", {20'b0, wr_addr}, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_redirect", seq_redirect_pc, 32'h0);

    // Commit pass-through in IDLE.
    commit_req = 1'b1; commit_addr = 12'h340; commit_data = 32'h1234;
    wq.push_back('{cyc, 12'h340, 32'h1234, 1'b1});
    tick();
    commit_req = 1'b0;
    tick();

    // Basic trap entry.
    run_trap(32'h1002, 32'h8000000B, 32'h55, 32'h8, 32'h80000101,
             32'h1000, 32'h1880, 32'h80000100);
    chk("redirect_hold", seq_redirect_pc, 32'h80000100);

    // MRET paths.
    run_mret(32'h1880, 32'h2000, 32'h1888, 32'h2000);
    run_mret(32'h8, 32'h3007, 32'h1880, 32'h3004);

    // Trap beats MRET when both are valid.
    mret_valid = 1'b1;
    run_trap(32'h4001, 32'h2, 32'hDEAD, 32'h0, 32'h404,
             32'h4000, 32'h1800, 32'h404);

    // Commit and trap together: commit first, trap accepted once commit drops.
    commit_req = 1'b1; commit_addr = 12'h305; commit_data = 32'hABCD;
    trap_valid = 1'b1; trap_pc = 32'h5000;
    #1;
    chk("ready_with_commit", {31'b0, req_ready}, 32'h0);
    wq.push_back('{cyc, 12'h305, 32'hABCD, 1'b1});
    tick();
    commit_req = 1'b0;
    run_trap(32'h5000, 32'h80000007, 32'h0, 32'h88, 32'h100,
             32'h5000, 32'h1880, 32'h100);

    // Reset in W_MCAUSE aborts the sequence.
    trap_pc = 32'h6006; trap_cause = 32'h5; trap_tval = 32'h9;
    trap_valid = 1'b1;
    wq.push_back('{cyc + 1, 12'h341, 32'h6004, 1'b0});
    wq.push_back('{cyc + 2, 12'h342, 32'h5, 1'b0});
    tick();
    trap_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_we", {31'b0, wr_we}, 32'h0);
    chk("abort_busy", {31'b0, seq_busy}, 32'h0);
    chk("abort_done", {31'b0, seq_done}, 32'h0);
    chk("abort_redirect", seq_redirect_pc, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_trap(32'h7000, 32'hB, 32'h77, 32'h1808, 32'h8000,
             32'h7000, 32'h1880, 32'h8000);

    for (int i = 0; i < 20; i++) begin
      if (wq.size() != 0 || dq.size() != 0) tick();
    end
    chk("write_queue_empty", wq.size(), 32'h0);
    chk("done_queue_empty", dq.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
